// File: rtl/sun_trb_sar_pkg.sv
// Shared types and default sizing for the SUN_TRB SAR controller.
// State encoding and constants used by the controller and its timeout counter.
package sun_trb_sar_pkg;

  localparam int SAR_NBITS      = 8;
  localparam int SAR_SAMPLE_CYC = 2;
  localparam int SAR_TMO_CYC    = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SMP,
    S_CMP,
    S_DEC,
    S_CRST,
    S_HOLD
  } sar_state_t;

endpackage

// File: rtl/sun_trb_sar_tmo.sv
// Comparator timeout counter for the SUN_TRB SAR controller.
// Counts cycles spent in one CMP or CRST visit; hit fires on the TMO_CYC-th cycle.
module sun_trb_sar_tmo
  import sun_trb_sar_pkg::*;
#(
  parameter int TMO_CYC = SAR_TMO_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  sar_state_t state,
  output logic       hit
);

  localparam int CW = $clog2(TMO_CYC + 1);

  sar_state_t    prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  logic          run;

  assign run = (state == S_CMP) || (state == S_CRST);

  // A fresh visit (state just changed) restarts the count at zero.
  assign cnt_eff = (state != prev) ? '0 : cnt;
  assign hit     = run && (cnt_eff == CW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= S_IDLE;
      cnt  <= '0;
    end else begin
      prev <= state;
      cnt  <= (run && !hit) ? cnt_eff + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/sun_trb_sar_ctrl.sv
// SAR sequencer for the SUN_TRB differential ADC: sample, N decisions, handshake.
// Optional comparator timeout is enabled by defining SAR_CMP_TIMEOUT_EN.
module sun_trb_sar_ctrl
  import sun_trb_sar_pkg::*;
#(
  parameter int NBITS      = SAR_NBITS,
  parameter int SAMPLE_CYC = SAR_SAMPLE_CYC,
  parameter int TMO_CYC    = SAR_TMO_CYC
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             CMP_P,
  input  logic             CMP_N,
  output logic             SAMPLE,
  output logic             CMP_EN,
  output logic [NBITS-1:0] CP,
  output logic [NBITS-1:0] CN,
  output logic             BUSY,
  output logic [NBITS-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             TMO_FLAG
);

  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC + 1) : 1;

  sar_state_t    state;
  logic [KW-1:0] k;
  logic [SW-1:0] smp_cnt;
  logic          dec;
  logic          tmo_hit;

`ifdef SAR_CMP_TIMEOUT_EN
  sun_trb_sar_tmo #(
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .clk  (CK),
    .rst_n(RN),
    .state(state),
    .hit  (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CK) begin
    if (!RN) begin
      state    <= S_IDLE;
      SAMPLE   <= 1'b0;
      CMP_EN   <= 1'b0;
      CP       <= '1;
      CN       <= '1;
      DOUT     <= '0;
      DVALID   <= 1'b0;
      BUSY     <= 1'b0;
      TMO_FLAG <= 1'b0;
      k        <= '0;
      smp_cnt  <= '0;
      dec      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            state    <= S_SMP;
            BUSY     <= 1'b1;
            SAMPLE   <= 1'b1;
            CP       <= '1;
            CN       <= '1;
            DOUT     <= '0;
            TMO_FLAG <= 1'b0;
            smp_cnt  <= '0;
          end
        end
        S_SMP: begin
          if (smp_cnt == SW'(SAMPLE_CYC - 1)) begin
            SAMPLE <= 1'b0;
            CMP_EN <= 1'b1;
            k      <= KW'(NBITS - 1);
            state  <= S_CMP;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end
        S_CMP: begin
          // Latch the decision here so DEC does not depend on CMP_P glitches.
          if (CMP_P ^ CMP_N) begin
            dec   <= CMP_P;
            state <= S_DEC;
          end else if (tmo_hit) begin
            dec      <= 1'b0;
            TMO_FLAG <= 1'b1;
            state    <= S_DEC;
          end
        end
        S_DEC: begin
          DOUT[k] <= dec;
          if (dec) CP[k] <= 1'b0;
          else     CN[k] <= 1'b0;
          CMP_EN <= 1'b0;
          state  <= S_CRST;
        end
        S_CRST: begin
          if ((!CMP_P && !CMP_N) || tmo_hit) begin
            if (CMP_P || CMP_N) TMO_FLAG <= 1'b1;
            if (k == '0) begin
              DVALID <= 1'b1;
              state  <= S_HOLD;
            end else begin
              k      <= k - 1'b1;
              CMP_EN <= 1'b1;
              state  <= S_CMP;
            end
          end
        end
        S_HOLD: begin
          if (DREADY) begin
            DVALID   <= 1'b0;
            BUSY     <= 1'b0;
            CP       <= '1;
            CN       <= '1;
            TMO_FLAG <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sun_trb_sar_ctrl.sv
// Randomized scoreboard bench for sun_trb_sar_ctrl with a behavioural comparator.
// Expected codes come from the SAR search rule; a monitor checks every accept.
module tb_sun_trb_sar_ctrl;

  localparam int NB = 8;
  localparam int SC = 2;

  logic          CK = 1'b0;
  logic          RN;
  logic          START;
  logic          CMP_P;
  logic          CMP_N;
  logic          SAMPLE;
  logic          CMP_EN;
  logic [NB-1:0] CP;
  logic [NB-1:0] CN;
  logic          BUSY;
  logic [NB-1:0] DOUT;
  logic          DVALID;
  logic          DREADY;
  logic          TMO_FLAG;

  typedef struct {
    logic [NB-1:0] dout;
    logic [NB-1:0] cp;
    logic [NB-1:0] cn;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Comparator plant state
  int cx    = 0;
  int cdly  = 0;
  int cstuck = -1;
  int hi    = 0;
  int lo    = 99;
  int bk    = -1;
  int acc   = 0;
  bit dec   = 0;
  bit fired = 0;
  bit act   = 0;
  bit dv_seen = 0;

  sun_trb_sar_ctrl dut (
    .CK      (CK),
    .RN      (RN),
    .START   (START),
    .CMP_P   (CMP_P),
    .CMP_N   (CMP_N),
    .SAMPLE  (SAMPLE),
    .CMP_EN  (CMP_EN),
    .CP      (CP),
    .CN      (CN),
    .BUSY    (BUSY),
    .DOUT    (DOUT),
    .DVALID  (DVALID),
    .DREADY  (DREADY),
    .TMO_FLAG(TMO_FLAG)
  );

  always #5 CK = ~CK;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  // Ideal SAR search on an analog level x; a stuck bit is resolved as 0.
  function automatic int ref_sar(input int x, input int stuck);
    int r = 0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (b != stuck && x >= r + (1 << b)) r += (1 << b);
    end
    return r;
  endfunction

  // Comparator: resolves cdly cycles late, clears cdly cycles late.
  always @(negedge CK) begin
    if (!RN) begin
      hi = 0; lo = 99; act = 0; fired = 0; bk = -1; acc = 0;
    end else begin
      if (SAMPLE) begin
        bk = NB - 1;
        acc = 0;
      end
      if (CMP_EN) begin
        lo = 0;
        hi++;
        if (hi == 1) begin
          fired = 0;
          dec = (bk != cstuck) && (cx >= acc + (1 << bk));
        end
        act = (bk != cstuck) && (hi > cdly);
        if (act) fired = 1;
      end else begin
        if (hi > 0) begin
          if (dec) acc += (1 << bk);
          bk--;
        end
        hi = 0;
        if (lo < 99) lo++;
        act = fired && (lo <= cdly);
      end
    end
    if (DVALID) dv_seen = 1;
  end

  assign CMP_P = act & dec;
  assign CMP_N = act & ~dec;

  // Monitor: every accepted result is popped and compared.
  always @(negedge CK) begin
    if (RN && DVALID && DREADY) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", DOUT, e.dout);
        chk("cp_final", CP, e.cp);
        chk("cn_final", CN, e.cn);
        chk("tmo_flag", TMO_FLAG, e.tmo);
      end
    end
  end

  task automatic chk_reset();
    chk("rst_sample", SAMPLE, 0);
    chk("rst_cmp_en", CMP_EN, 0);
    chk("rst_cp", CP, 8'hFF);
    chk("rst_cn", CN, 8'hFF);
    chk("rst_dout", DOUT, 0);
    chk("rst_dvalid", DVALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_tmo", TMO_FLAG, 0);
  endtask

  task automatic do_reset();
    RN = 1'b0;
    START = 1'b0;
    DREADY = 1'b0;
    @(posedge CK); #1;
    chk_reset();
    @(posedge CK); #1;
    RN = 1'b1;
  endtask

  task automatic run_conv(input int x, input int dly,
                          input int stuck, input int hold,
                          input bit chk_lat, input bit spam,
                          input bit soa);
    exp_t e;
    int   code;
    int   n = 0;
    int   lat;
    bit   stable = 1;
    logic [NB-1:0] d0;
    code = (stuck < 0) ? x : ref_sar(x, stuck);
    e.dout = NB'(code);
    e.cp = ~NB'(code);
    e.cn = NB'(code);
    e.tmo = (stuck >= 0);
    sb.push_back(e);
    cx = x;
    cdly = dly;
    cstuck = stuck;
    lat = 1 + SC + 3 * NB + NB * 2 * dly;
    DREADY = 1'b0;
    START = 1'b1;
    while (n < 600) begin
      @(posedge CK); #1;
      n++;
      if (n == 1) begin
        chk("smp_entry", {SAMPLE, BUSY}, 2'b11);
      end
      if (DVALID) break;
      START = spam ? 1'($urandom % 2) : 1'b0;
    end
    START = 1'b0;
    if (!DVALID) begin
      chk("dvalid_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
      do_reset();
      return;
    end
    if (chk_lat) chk("latency", n, lat);
    d0 = DOUT;
    for (int h = 0; h < hold; h++) begin
      @(posedge CK); #1;
      if (DOUT !== d0 || DVALID !== 1'b1) stable = 0;
    end
    if (hold > 0) chk("hold_stable", stable, 1);
    DREADY = 1'b1;
    START = soa;
    @(posedge CK); #1;
    DREADY = 1'b0;
    START = 1'b0;
    chk("acc_dvalid", DVALID, 0);
    chk("acc_busy", BUSY, 0);
    chk("acc_cpcn", {CP, CN}, 16'hFFFF);
    chk("acc_tmo", TMO_FLAG, 0);
    if (soa) begin
      @(posedge CK); #1;
      chk("soa_ignored", {SAMPLE, BUSY}, 2'b00);
    end
    cstuck = -1;
  endtask

  initial begin
    RN = 1'b0;
    START = 1'b0;
    DREADY = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk_reset();
    RN = 1'b1;

    // Abort a conversion in flight.
    cx = 8'h3C;
    START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    repeat (12) @(posedge CK);
    #1;
    dv_seen = 0;
    do_reset();
    repeat (3) @(posedge CK);
    #1;
    chk("abort_no_dvalid", dv_seen, 0);
    chk("abort_busy", BUSY, 0);

    run_conv(8'hA5, 0, -1, 10, 1, 0, 0);
    run_conv(8'hA5, 0, -1, 0, 1, 0, 1);
    run_conv(8'h5A, 4, -1, 2, 1, 0, 0);
    run_conv(8'h00, 0, -1, 1, 1, 1, 0);
    run_conv(8'hFF, 1, -1, 1, 1, 1, 0);

    for (int i = 0; i < 16; i++) begin
      run_conv(int'($urandom % 256), int'($urandom % 4), -1,
               int'($urandom % 4), 1, 1'($urandom % 2),
               1'($urandom % 2));
    end

`ifdef SAR_CMP_TIMEOUT_EN
    run_conv(8'h4B, 0, 3, 1, 0, 0, 0);
    run_conv(8'hC8, 2, 3, 0, 0, 0, 0);
`else
    cx = 8'h4B;
    cstuck = 3;
    START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    repeat (80) @(posedge CK);
    #1;
    chk("stuck_busy", BUSY, 1);
    chk("stuck_cmp_en", CMP_EN, 1);
    chk("stuck_dvalid", DVALID, 0);
    chk("stuck_tmo", TMO_FLAG, 0);
    do_reset();
    cstuck = -1;
`endif

    run_conv(8'h81, 0, -1, 0, 1, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
